// File: rtl/alu_flag_writeback_if.sv
// alu_flag_writeback_if: handshake bundle between the ALU producer, the
// flag/writeback stage and the register-file writeback consumer.
// master = environment (ALU side drives in_*, writeback drives out_ready).
// slave  = the alu_flag_writeback block.
interface alu_flag_writeback_if #(
  parameter int N = 8
);
  // ALU -> block
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_result;
  logic [3:0]   in_flags;
  logic         in_set_flags;
  logic [3:0]   in_cond;

  // block -> writeback
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [3:0]   out_flags;
  logic         out_wen;

  modport master (
    output in_valid, in_result, in_flags, in_set_flags, in_cond, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_wen
  );

  modport slave (
    input  in_valid, in_result, in_flags, in_set_flags, in_cond, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_wen
  );
endinterface

// File: rtl/alu_flag_writeback.sv
// alu_flag_writeback: captures ALU result + NZCV flags through a valid/ready
// handshake, evaluates the op's condition code against the architectural
// status register (flags_q), updates flags_q for passing flag-setting ops and
// queues {result, flags, pass} in a 2-entry FIFO toward writeback.
//
// Build option: define ALU_COND_EVAL_EN to enable condition evaluation.
// Without it in_cond is ignored and every op passes (out_wen = 1).
module alu_flag_writeback #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_flag_writeback_if.slave  bus,
  output logic [3:0]           flags_q
);

  localparam int DEPTH = 2;

  // FIFO storage, one field array per entry component.
  logic [N-1:0] result_mem [DEPTH];
  logic [3:0]   flags_mem  [DEPTH];
  logic         wen_mem    [DEPTH];

  logic         head_ptr;
  logic         tail_ptr;
  logic [1:0]   count;

  logic         accept;
  logic         pop;
  logic         pass;

  // Handshake status comes only from registered count, never from out_ready.
  assign bus.in_ready  = (count < 2'd2);
  assign bus.out_valid = (count != 2'd0);

  assign accept = bus.in_valid  && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

`ifdef ALU_COND_EVAL_EN
  logic f_n, f_z, f_c, f_v;
  assign {f_n, f_z, f_c, f_v} = flags_q;

  // Evaluate in_cond against the flags as they stand before this op updates them.
  always_comb begin
    // NOTE: default assigned first so every path drives pass; no latch is inferred.
    pass = 1'b1;
    case (bus.in_cond)
      4'b0000: pass = f_z;
      4'b0001: pass = !f_z;
      4'b0010: pass = f_c;
      4'b0011: pass = !f_c;
      4'b0100: pass = f_n;
      4'b0101: pass = !f_n;
      4'b0110: pass = f_v;
      4'b0111: pass = !f_v;
      4'b1000: pass = f_c && !f_z;
      4'b1001: pass = !f_c || f_z;
      4'b1010: pass = (f_n == f_v);
      4'b1011: pass = (f_n != f_v);
      4'b1100: pass = !f_z && (f_n == f_v);
      4'b1101: pass = f_z || (f_n != f_v);
      default: pass = 1'b1;
    endcase
  end
`else
  // Condition evaluation disabled: every op passes, in_cond is ignored.
  logic unused_cond;
  assign unused_cond = ^bus.in_cond;
  assign pass        = 1'b1;
`endif

  // Pointer and occupancy bookkeeping; accept+pop together leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (accept) tail_ptr <= ~tail_ptr;
      if (pop)    head_ptr <= ~head_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Write the accepted op into the tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is only two entries, so it is cleared on reset to keep
      // the undriven head outputs at a known 0 rather than X.
      for (int i = 0; i < DEPTH; i++) begin
        result_mem[i] <= '0;
        flags_mem[i]  <= 4'b0000;
        wen_mem[i]    <= 1'b0;
      end
    end else if (accept) begin
      result_mem[tail_ptr] <= bus.in_result;
      flags_mem[tail_ptr]  <= bus.in_flags;
      wen_mem[tail_ptr]    <= pass;
    end
  end

  // Architectural status register: only passing flag-setting ops change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (accept && bus.in_set_flags && pass) begin
      flags_q <= bus.in_flags;
    end
  end

  // Head entry drives the writeback port directly; meaningless when out_valid=0.
  assign bus.out_result = result_mem[head_ptr];
  assign bus.out_flags  = flags_mem[head_ptr];
  assign bus.out_wen    = wen_mem[head_ptr];

endmodule

// File: doc/alu_flag_writeback.md
# alu_flag_writeback

Downstream stage of the 8-bit ALU. It captures each ALU result and its NZCV flags through a valid/ready handshake and evaluates a 4-bit condition code against the architectural status register. It updates that register on flag-setting operations and buffers results in a 2-entry FIFO toward the register-file writeback port. The ALU stays purely combinational; this block owns all flag state and the backpressure.

## Interface
- N, default 8: result width; matches the ALU operand and result width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU result/flags on in_* are valid.
- in_ready  out  1  block can accept; equals (count < 2).
- in_result  in  N  ALU Result.
- in_flags  in  4  ALU flags {N,Z,C,V}, bit3 = N, bit0 = V.
- in_set_flags  in  1  operation updates the status register if its condition passes.
- in_cond  in  4  condition code for this operation.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  writeback consumes the head.
- out_result  out  N  head result.
- out_flags  out  4  head's captured ALU flags.
- out_wen  out  1  head's condition passed; writeback commits only when 1.
- flags_q  out  4  architectural status register {N,Z,C,V}.

## Operation
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Condition evaluated combinationally on in_cond against current flags_q, before the accepted op's own update:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 and 1111 always.
- On accept: push {in_result, in_flags, pass} at tail. If in_set_flags && pass, flags_q <= in_flags. A failed op is still pushed with out_wen=0 and never alters flags_q.
- FIFO: depth 2, head/tail pointers, 2-bit count (0..2).
- Outputs come from the head entry. The head is held stable while out_valid && !out_ready.
- Accept and pop in the same cycle: count unchanged and order preserved. At count=2 no accept is possible because in_ready=0.
- Pop at count=0 cannot occur because out_valid=0.
- out_result, out_flags and out_wen are don't-care when out_valid=0. The implementation drives them from the head entry without gating.

## Timing
- Reset values: count=0, pointers=0, out_valid=0, in_ready=1, flags_q=4'b0000. FIFO contents are cleared to 0.
- Latency: op accepted at edge t, out_valid=1 after edge t, one cycle, when the FIFO was empty.
- flags_q updates at the accepting edge. An op accepted at edge t+1 sees the flags of the op accepted at t, so back-to-back ops have no hazard.
- in_ready is derived only from registered count, with no combinational path from out_ready.
- Reset asserted mid-operation discards all buffered entries immediately and asynchronously. No partial pop or flag update survives.

## Configuration
- ALU_COND_EVAL_EN defined: condition evaluation as above.
- Undefined: in_cond is ignored and pass is constant 1. out_wen is always 1 for valid entries, and flags_q updates on every accept with in_set_flags=1. Ports are identical in both builds.

## Test plan
- Reset then single op: in_result=8'hFE, in_flags=4'b1010 (255+255), in_set_flags=1, in_cond=1110 -> next cycle out_valid=1, out_result=8'hFE, out_wen=1, flags_q=4'b1010.
- Condition pass/fail with flags_q=4'b1010:
  - in_cond=0010 (CS), result 8'h19 -> out_wen=1.
  - in_cond=0011 (CC), in_set_flags=1, in_flags=4'b0100 -> out_wen=0 and flags_q stays 4'b1010.
  - Without ALU_COND_EVAL_EN the CC op gives out_wen=1 and flags_q=4'b0100.
- Backpressure: out_ready=0, offer 8'h01, 8'h02, 8'h03 on consecutive cycles -> first two accepted, in_ready=0 from the second accept, 8'h03 held. Raising out_ready pops 8'h01, 8'h02, 8'h03 in order.
- Simultaneous accept/pop at count=1 with out_ready=1 every cycle and in_valid=1 every cycle -> count stays 1, one result out per cycle, in_ready never drops.
- GE/LT after signed subtract: flags_q set to 4'b1001 (N=1, V=1) -> in_cond=1010 gives out_wen=1, in_cond=1011 gives out_wen=0.
- Reset mid-operation: count=2, flags_q=4'b0110, pull rst_n low between edges -> out_valid=0, in_ready=1, flags_q=4'b0000 immediately. After release, first accepted op appears alone at the head.
